// File: rtl/wb_hyperram_pkg.sv
// Shared types and defaults for the HyperRAM Wishbone arbiter.
//   arb_state_e  : arbiter FSM states
//   DEF_TIMEOUT  : default watchdog abort threshold in cycles
//   DEF_TO_W     : default watchdog counter width
//   sel_w()      : Wishbone byte-select width for a given data width
package wb_hyperram_pkg;

    localparam int unsigned DEF_TIMEOUT = 255;
    localparam int unsigned DEF_TO_W    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } arb_state_e;

    // One select line per byte lane.
    function automatic int unsigned sel_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/wb_hyperram_watchdog.sv
// Stall watchdog: counts cycles a strobe waits unacknowledged.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count (no strobe, or strobe acknowledged)
//   en         : strobe stalled this cycle
//   expire_c   : combinational pulse while stalled with the count at LIMIT
// The count saturates at LIMIT and never wraps.
module wb_watchdog #(
    parameter int unsigned LIMIT = 255,
    parameter int unsigned W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] count_q;

    // Stall counter with clear priority and saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != LIMIT_V)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign expire_c = en & (count_q == LIMIT_V);

endmodule

// File: rtl/wb_hyperram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the wb_hyperram slave.
//   wb_clk_i, wb_rstn_i : clock, asynchronous active-low reset
//   m0_* / m1_*         : master-side Wishbone ports (cyc/stb/we/sel/adr/dat in, ack/err/dat out)
//   s_*                 : slave-side Wishbone port towards wb_hyperram
//   grant_o             : one-hot owner (01 = m0, 10 = m1, 00 = none)
//   timeout_o           : one-cycle pulse when the watchdog aborts a stalled strobe
// Ownership is locked for the whole cyc; the slave bus is a combinational
// mux of the owner, so only the grant decision costs a cycle.
module wb_hyperram_arbiter
    import wb_hyperram_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned TO_W    = DEF_TO_W
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rstn_i,

    input  logic                      m0_cyc_i,
    input  logic                      m0_stb_i,
    input  logic                      m0_we_i,
    input  logic [sel_w(DATA_W)-1:0]  m0_sel_i,
    input  logic [ADDR_W-1:0]         m0_adr_i,
    input  logic [DATA_W-1:0]         m0_dat_i,
    output logic                      m0_ack_o,
    output logic                      m0_err_o,
    output logic [DATA_W-1:0]         m0_dat_o,

    input  logic                      m1_cyc_i,
    input  logic                      m1_stb_i,
    input  logic                      m1_we_i,
    input  logic [sel_w(DATA_W)-1:0]  m1_sel_i,
    input  logic [ADDR_W-1:0]         m1_adr_i,
    input  logic [DATA_W-1:0]         m1_dat_i,
    output logic                      m1_ack_o,
    output logic                      m1_err_o,
    output logic [DATA_W-1:0]         m1_dat_o,

    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [sel_w(DATA_W)-1:0]  s_sel_o,
    output logic [ADDR_W-1:0]         s_adr_o,
    output logic [DATA_W-1:0]         s_dat_o,
    input  logic                      s_ack_i,
    input  logic [DATA_W-1:0]         s_dat_i,

    output logic [1:0]                grant_o,
    output logic                      timeout_o
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;     // 0 = m0 owned last, 1 = m1 owned last
    logic       req0, req1;
    logic       stb_c;
    logic       expire_c;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // Slave strobe as seen by the watchdog, kept outside the output mux.
    assign stb_c = ((state_q == GRANT0) & req0) | ((state_q == GRANT1) & req1);

    wb_watchdog #(
        .LIMIT (TIMEOUT),
        .W     (TO_W)
    ) u_watchdog (
        .clk      (wb_clk_i),
        .rst_n    (wb_rstn_i),
        .clr      (~stb_c | s_ack_i),
        .en       (stb_c & ~s_ack_i),
        .expire_c (expire_c)
    );

    // State and round-robin history.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state decision and owner-to-slave muxing.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m0_dat_o  = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        m1_dat_o  = '0;
        grant_o   = 2'b00;
        timeout_o = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the master that did not own last time wins.
                if (req0 && (!req1 || last_q)) begin
                    state_d = GRANT0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = GRANT1;
                    last_d  = 1'b1;
                end
            end

            GRANT0: begin
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = req0;
                s_we_o    = m0_we_i;
                s_sel_o   = m0_sel_i;
                s_adr_o   = m0_adr_i;
                s_dat_o   = m0_dat_i;
                m0_ack_o  = s_ack_i;
                m0_dat_o  = s_dat_i;
                m0_err_o  = expire_c;
                timeout_o = expire_c;
                grant_o   = 2'b01;
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                end else if (expire_c) begin
                    state_d = ABORT;
                end
            end

            GRANT1: begin
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = req1;
                s_we_o    = m1_we_i;
                s_sel_o   = m1_sel_i;
                s_adr_o   = m1_adr_i;
                s_dat_o   = m1_dat_i;
                m1_ack_o  = s_ack_i;
                m1_dat_o  = s_dat_i;
                m1_err_o  = expire_c;
                timeout_o = expire_c;
                grant_o   = 2'b10;
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                end else if (expire_c) begin
                    state_d = ABORT;
                end
            end

            ABORT: begin
                // Slave is cut off; late acks are swallowed until the owner lets go.
                grant_o = last_q ? 2'b10 : 2'b01;
                if (!(last_q ? m1_cyc_i : m0_cyc_i)) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
